seven_segment_scanner: RTL and testbench

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_scanner.sv | 129 ++++++++++++
 tb/tb_seven_segment_scanner.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Eight-digit multiplexed seven-segment scanner: BLANK/DRIVE slots per digit, frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZ_BLANK_EN.
module seven_segment_scanner #(
  parameter int PRESCALE = 100000,
  parameter int BLANK    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic        load,
  input  logic [7:0]  digit_en,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        frame_tick,
  output logic        load_pending
);

  localparam int MAX_COUNT = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(PRESCALE - 1);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [2:0]    idx;
  logic [31:0]   display;
  logic [31:0]   pending;

  logic [3:0]    nibble;
  logic [6:0]    drive_seg;
  logic          boundary;
`ifdef SEVSEG_LZ_BLANK_EN
  logic          upper_zero;
`endif

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0010000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      4'hF: hex_decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    // NOTE: each combinational signal is assigned unconditionally before any override, so no latch is inferred.
    nibble    = display[{idx, 2'b00} +: 4];
    drive_seg = hex_decode(nibble);
`ifdef SEVSEG_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero; digit 0 always shows.
    upper_zero = (idx != 3'd0) && ((display >> {idx, 2'b00}) == 32'd0);
    if (upper_zero) drive_seg = 7'h7F;
`endif
    boundary = (state == ST_DRIVE) && (count == DRIVE_LAST) && (idx == 3'd7);
  end

  // NOTE: all state here updates with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_BLANK;
      count        <= '0;
      idx          <= '0;
      display      <= '0;
      pending      <= '0;
      load_pending <= 1'b0;
      seg          <= 7'h7F;
      an           <= 8'hFF;
      frame_tick   <= 1'b0;
    end else begin
      frame_tick <= 1'b0;

      case (state)
        ST_BLANK: begin
          if (count == BLANK_LAST) begin
            state <= ST_DRIVE;
            count <= '0;
            // digit_en is sampled only here, so mid-slot changes land in the next slot.
            an    <= digit_en[idx] ? ~(8'b1 << idx) : 8'hFF;
            seg   <= drive_seg;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (count == DRIVE_LAST) begin
            state      <= ST_BLANK;
            count      <= '0;
            idx        <= idx + 3'd1;
            an         <= 8'hFF;
            seg        <= 7'h7F;
            frame_tick <= (idx == 3'd7);
          end else begin
            count <= count + 1'b1;
          end
        end
      endcase

      // The display register moves only on the frame boundary; the newest load always wins.
      if (load) pending <= value;
      if (boundary && load) begin
        display      <= value;
        load_pending <= 1'b0;
      end else if (boundary && load_pending) begin
        display      <= pending;
        load_pending <= 1'b0;
      end else if (load) begin
        load_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (PRESCALE=4, BLANK=2): directed scenarios plus random
// stimulus compared against an edge-count reference model.
module tb_seven_segment_scanner;

  localparam int PRESCALE = 4;
  localparam int BLANK    = 2;
  localparam int SLOT     = PRESCALE + BLANK;
  localparam int FRAME    = 8 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = '0;
  logic        load = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        frame_tick;
  logic        load_pending;

  int n_checks = 0;
  int n_fail   = 0;

  seven_segment_scanner #(.PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .value        (value),
    .load         (load),
    .digit_en     (digit_en),
    .seg          (seg),
    .an           (an),
    .frame_tick   (frame_tick),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [7:0] scan_an [1:8] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFD};

  // Reference model: position in the scan follows purely from the number of edges since reset.
  int          m_edge;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  bit          m_lp;
  bit          m_en_bit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge = 0; m_disp = '0; m_pend = '0; m_lp = 0; m_en_bit = 0;
    end else begin
      m_edge = m_edge + 1;
      if (m_edge >= BLANK && (m_edge - BLANK) % SLOT == 0)
        m_en_bit = digit_en[((m_edge - BLANK) / SLOT) % 8];
      if (load && m_edge % FRAME == 0) begin
        m_disp = value; m_lp = 0;
      end else if (load) begin
        m_pend = value; m_lp = 1;
      end else if (m_edge % FRAME == 0 && m_lp) begin
        m_disp = m_pend; m_lp = 0;
      end
    end
  end

  function automatic bit m_driving();
    return m_edge >= BLANK && ((m_edge - BLANK) % SLOT) < PRESCALE;
  endfunction

  function automatic int m_slot();
    return ((m_edge - BLANK) / SLOT) % 8;
  endfunction

  function automatic logic [7:0] exp_an();
    logic [7:0] one_hot;
    if (!m_driving() || !m_en_bit) return 8'hFF;
    one_hot = 8'b1 << m_slot();
    return ~one_hot;
  endfunction

  function automatic logic [6:0] exp_seg();
    int s;
    if (!m_driving()) return 7'h7F;
    s = m_slot();
`ifdef SEVSEG_LZ_BLANK_EN
    if (s > 0 && (m_disp >> (4 * s)) == 32'd0) return 7'h7F;
`endif
    return hex_tab[m_disp[4*s +: 4]];
  endfunction

  function automatic bit exp_tick();
    return m_edge > 0 && m_edge % FRAME == 0;
  endfunction

  function automatic int an_slot(input logic [7:0] a);
    for (int k = 0; k < 8; k++)
      if (a == ~(8'b1 << k)) return k;
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      cyc();
      n_checks++;
      if ({seg, an, frame_tick, load_pending} !== {7'h7F, 8'hFF, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_outputs seg=%b an=%h tick=%b lp=%b expected seg=1111111 an=ff tick=0 lp=0",
                 seg, an, frame_tick, load_pending);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan_timing();
    digit_en = 8'hFF;
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      cyc();
      n_checks++;
      if (an !== scan_an[e]) begin
        n_fail++;
        $display("FAIL scan_an edge=%0d an=%h expected=%h", e, an, scan_an[e]);
      end
      if (e >= 2 && e <= 5) begin
        n_checks++;
        if (seg !== 7'b1000000) begin
          n_fail++;
          $display("FAIL scan_seg edge=%0d seg=%b expected=1000000", e, seg);
        end
      end
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      cyc();
      n_checks++;
      if ({seg, an, frame_tick, load_pending} !== {exp_seg(), exp_an(), exp_tick(), m_lp}) begin
        n_fail++;
        $display("FAIL scan_model edge=%0d seg=%b an=%h tick=%b lp=%b expected %b %h %b %b",
                 m_edge, seg, an, frame_tick, load_pending, exp_seg(), exp_an(), exp_tick(), m_lp);
      end
    end
  endtask

  task automatic test_load_mid_frame();
    bit got_tick = 0;
    int seen = 0;
    digit_en = 8'hFF;
    do_reset();
    repeat (20) cyc();
    value = 32'h0000_00A5;
    load  = 1'b1;
    cyc();
    load  = 1'b0;
    n_checks++;
    if (load_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL load_pending_set lp=%b expected=1", load_pending);
    end
    for (int c = 0; c < 2 * FRAME && !got_tick; c++) begin
      cyc();
      if (frame_tick === 1'b1) got_tick = 1;
      else if (load_pending !== 1'b1) begin
        n_checks++; n_fail++;
        $display("FAIL load_pending_hold edge=%0d lp=%b expected=1", m_edge, load_pending);
      end
    end
    n_checks++;
    if (!got_tick || load_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL load_boundary tick_seen=%b lp=%b expected tick_seen=1 lp=0", got_tick, load_pending);
    end
    cyc();
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_width tick=%b expected=0", frame_tick);
    end
    for (int c = 1; c < FRAME; c++) begin
      cyc();
      if (an == 8'hFE || an == 8'hFD) begin
        n_checks++;
        seen++;
        if (seg !== ((an == 8'hFE) ? 7'b0010010 : 7'b0001000)) begin
          n_fail++;
          $display("FAIL load_a5_digit an=%h seg=%b expected=%b", an, seg,
                   (an == 8'hFE) ? 7'b0010010 : 7'b0001000);
        end
      end
    end
    n_checks++;
    if (seen != 2 * PRESCALE) begin
      n_fail++;
      $display("FAIL load_a5_slots seen=%0d expected=%0d", seen, 2 * PRESCALE);
    end
  endtask

  task automatic test_multi_load();
    bit got_tick = 0;
    repeat (5) cyc();
    value = 32'h1111_1111; load = 1'b1; cyc(); load = 1'b0;
    repeat (5) cyc();
    value = 32'h2222_2222; load = 1'b1; cyc(); load = 1'b0;
    n_checks++;
    if (load_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_pending lp=%b expected=1", load_pending);
    end
    for (int c = 0; c < 3 * FRAME && !got_tick; c++) begin
      cyc();
      got_tick = frame_tick;
      n_checks++;
      if (seg === 7'b1111001) begin
        n_fail++;
        $display("FAIL multi_no_one edge=%0d seg=%b expected not 1111001", m_edge, seg);
      end
    end
    for (int c = 1; c < FRAME; c++) begin
      cyc();
      if (an != 8'hFF) begin
        n_checks++;
        if (seg !== 7'b0100100) begin
          n_fail++;
          $display("FAIL multi_last_wins an=%h seg=%b expected=0100100", an, seg);
        end
      end
    end
  endtask

  task automatic test_load_on_boundary();
    logic [31:0] v;
    int k;
    for (int c = 0; c < 2 * FRAME && (m_edge % FRAME) != FRAME - 1; c++) cyc();
    v = $urandom | 32'h1000_0000;
    value = v; load = 1'b1; cyc(); load = 1'b0;
    n_checks++;
    if ({frame_tick, load_pending} !== 2'b10) begin
      n_fail++;
      $display("FAIL boundary_load tick=%b lp=%b expected tick=1 lp=0", frame_tick, load_pending);
    end
    for (int c = 1; c < FRAME; c++) begin
      cyc();
      k = an_slot(an);
      if (k >= 0) begin
        n_checks++;
        if (seg !== hex_tab[v[4*k +: 4]] || load_pending !== 1'b0) begin
          n_fail++;
          $display("FAIL boundary_show digit=%0d seg=%b lp=%b expected seg=%b lp=0",
                   k, seg, load_pending, hex_tab[v[4*k +: 4]]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(9) == 0) digit_en = 8'($urandom);
      load = ($urandom_range(29) == 0);
      if (load) value = $urandom & ($urandom_range(1) ? 32'hFFFF_FFFF : 32'h0000_0FFF);
      cyc();
      n_checks++;
      if ({seg, an, frame_tick, load_pending} !== {exp_seg(), exp_an(), exp_tick(), m_lp}) begin
        n_fail++;
        $display("FAIL random_model edge=%0d seg=%b an=%h tick=%b lp=%b expected %b %h %b %b",
                 m_edge, seg, an, frame_tick, load_pending, exp_seg(), exp_an(), exp_tick(), m_lp);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    bit reached = 0;
    digit_en = 8'h01;
    do_reset();
    repeat (3) cyc();
    value = 32'hFFFF_FFFF; load = 1'b1; cyc(); load = 1'b0;
    for (int c = 0; c < 2 * FRAME && !reached; c++) begin
      cyc();
      n_checks++;
      if (an !== 8'hFF && an !== 8'hFE) begin
        n_fail++;
        $display("FAIL en_mask edge=%0d an=%h expected ff or fe", m_edge, an);
      end
      reached = m_driving() && m_slot() == 3 && ((m_edge - BLANK) % SLOT) == 1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (!reached || {seg, an, frame_tick, load_pending} !== {7'h7F, 8'hFF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset reached=%b seg=%b an=%h tick=%b lp=%b expected seg=1111111 an=ff tick=0 lp=0",
               reached, seg, an, frame_tick, load_pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    digit_en = 8'hFF;
    repeat (BLANK) cyc();
    n_checks++;
    if (an !== 8'hFE || seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL restart_digit0 an=%h seg=%b expected an=fe seg=1000000", an, seg);
    end
    for (int c = 0; c < FRAME; c++) begin
      cyc();
      n_checks++;
      if (seg === 7'b0001110 || load_pending !== 1'b0) begin
        n_fail++;
        $display("FAIL pending_discard edge=%0d seg=%b lp=%b expected no F and lp=0", m_edge, seg, load_pending);
      end
    end
  endtask

  task automatic test_lz();
    bit got_tick = 0;
    int k;
    logic [6:0] want;
    digit_en = 8'hFF;
    do_reset();
    repeat (3) cyc();
    value = 32'h0000_0305; load = 1'b1; cyc(); load = 1'b0;
    for (int c = 0; c < 2 * FRAME && !got_tick; c++) begin
      cyc();
      got_tick = frame_tick;
    end
    n_checks++;
    if (!got_tick) begin
      n_fail++;
      $display("FAIL lz_tick_timeout tick_seen=0 expected=1");
    end
    for (int c = 1; c < FRAME; c++) begin
      cyc();
      k = an_slot(an);
      if (k >= 0) begin
        case (k)
          0:       want = 7'b0010010;
          1:       want = 7'b1000000;
          2:       want = 7'b0110000;
`ifdef SEVSEG_LZ_BLANK_EN
          default: want = 7'h7F;
`else
          default: want = 7'b1000000;
`endif
        endcase
        n_checks++;
        if (seg !== want) begin
          n_fail++;
          $display("FAIL lz_digit digit=%0d seg=%b expected=%b", k, seg, want);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_timing();
    test_load_mid_frame();
    test_multi_load();
    test_load_on_boundary();
    test_random();
    test_reset_mid_drive();
    test_lz();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
